pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Power-up and reset sequencer for the board PLL (`myclock`). It drives the PLL's active-low POWERDOWN pin and watches the asynchronous LOCK output. It releases a clean active-high reset to downstream logic only after lock has been continuously stable, and it retries or flags failure when lock never arrives. It replaces the direct LOCK-to-`rst` tie-off in the top level and runs on the free-running reference clock (CLKA domain).

## Interface
- PD_CYCLES, 16: cycles POWERDOWN is held active before each PLL start attempt.
- LOCK_TIMEOUT, 4096: cycles allowed for lock to appear after power-up.
- STABLE_CYCLES, 256: consecutive cycles of synchronized lock required before reset release.
- MAX_RETRY, 3: power-cycle attempts before declaring failure.
- CNT_W, 16: width of the internal cycle counter. PD_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES must each be at least 1 and less than 2^CNT_W.

Ports:
- clk, in, 1: reference clock (CLKA). One clock only.
- rst, in, 1: synchronous, active-high reset.
- pll_lock, in, 1: PLL LOCK. Asynchronous to clk.
- restart, in, 1: one-cycle request to restart the sequence from power-down.
- pll_pd_n, out, 1: drives PLL POWERDOWN. 0 means powered down; 1 means running.
- sys_rst, out, 1: active-high reset for logic clocked by GLA. Consumers synchronize its deassertion in their own domain.
- pll_ready, out, 1: high exactly when in RUN.
- fail, out, 1: retries exhausted.
- state, out, 3: current state code, for debug.
- lol_cnt, out, 8: saturating count of loss-of-lock events seen in RUN.

## Operation
- pll_lock passes through a 2-flop synchronizer to produce lock_s. All decisions use lock_s only.
- Every output is registered. Output values follow the state entered on the same clock edge.
- PWRDN (code 0): pll_pd_n=0, sys_rst=1.
  - The counter runs from 0. At cnt==PD_CYCLES-1, go to WAIT_LOCK with cnt=0.
- WAIT_LOCK (code 1): pll_pd_n=1, sys_rst=1.
  - If lock_s=1, go to STABLE with cnt=0.
  - Otherwise, at cnt==LOCK_TIMEOUT-1, retry_cnt increments.
    - If the new retry_cnt equals MAX_RETRY, go to FAIL.
    - Otherwise go to PWRDN.
- STABLE (code 2): pll_pd_n=1, sys_rst=1.
  - If lock_s=0, return to WAIT_LOCK with cnt=0 and a fresh timeout. retry_cnt is unchanged.
  - If lock_s=1 at cnt==STABLE_CYCLES-1, go to RUN and clear retry_cnt.
- RUN (code 3): pll_pd_n=1, sys_rst=0, pll_ready=1.
  - If lock_s=0, go to WAIT_LOCK and increment lol_cnt, saturating at 255. The PLL stays powered and is allowed to relock.
- FAIL (code 4): pll_pd_n=0, sys_rst=1, fail=1.
  - Leaves only on rst or restart.
- restart=1 in any state: go to PWRDN with cnt=0 and retry_cnt=0; fail is cleared. lol_cnt is kept.
- Priority: rst > restart > lock_s and timer events. If restart coincides with lock loss in RUN, the next state is PWRDN and lol_cnt still increments.
- Codes 5-7 are unreachable. If entered, they recover to PWRDN on the next cycle.

## Timing
- Reset values: state=PWRDN, pll_pd_n=0, sys_rst=1, pll_ready=0, fail=0, lol_cnt=0, retry_cnt=0, cnt=0, synchronizer flops=0.
- After rst deasserts, pll_pd_n rises PD_CYCLES cycles later.
- From a pll_lock rising edge to entering STABLE: 3 cycles (2 synchronizer stages plus 1 registered decision).
- sys_rst falls STABLE_CYCLES cycles after entering STABLE, provided lock_s stays high throughout.
- From a pll_lock falling edge in RUN: sys_rst=1 and pll_ready=0 follow within 3 cycles.
- A lock glitch shorter than one clk period may be missed. This is acceptable because the PLL asserts LOCK for long periods.
- rst asserted mid-sequence forces the reset values on the next edge. pll_pd_n returns to 0 immediately.
- After restart is sampled, pll_pd_n=0 and sys_rst=1 on the next edge.

## Test plan
All scenarios use PD_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
1. Nominal start: release rst, then raise pll_lock 10 cycles after pll_pd_n rises.
   - pll_pd_n rises at cycle 4.
   - STABLE is entered 3 cycles after the lock edge.
   - sys_rst falls 8 cycles later; pll_ready=1 and state=3.
2. Glitch during STABLE: drop pll_lock for 3 cycles at STABLE cycle 5.
   - Returns to WAIT_LOCK; sys_rst stays 1.
   - After lock returns, STABLE restarts and the full 8-cycle count is required.
3. No lock: keep pll_lock=0.
   - Sequence: PWRDN(4), WAIT(20), PWRDN(4), WAIT(20), then FAIL.
   - In FAIL: fail=1, pll_pd_n=0, sys_rst=1, and the block stays there indefinitely.
4. Recovery from FAIL: pulse restart, then provide lock.
   - fail clears on the next edge and the nominal sequence completes.
   - lol_cnt is unchanged.
5. Loss of lock in RUN: drop pll_lock 3 times, relocking each time.
   - lol_cnt=3; sys_rst reasserts within 3 cycles of each drop.
   - pll_pd_n stays 1 throughout.
   - Force 300 drops: lol_cnt saturates at 255.
6. Priority and reset checks:
   - Assert rst in STABLE at cycle 6: next edge gives state=0 and pll_pd_n=0.
   - Assert restart on the same cycle as lock loss in RUN: state=PWRDN and lol_cnt increments.

Source files
------------

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: power-up / reset sequencer for the board PLL.
// Drives the PLL POWERDOWN pin, qualifies LOCK and releases a clean
// active-high reset once lock has been continuously stable.
`timescale 1ns/1ps
module pll_reset_seq #(
  parameter int unsigned PD_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_pd_n,
  output logic       sys_rst,
  output logic       pll_ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] lol_cnt
);

  localparam int unsigned RETRY_W = 8;
  localparam int unsigned LOL_W   = 8;

  localparam logic [CNT_W-1:0]   PD_LAST     = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
  localparam logic [LOL_W-1:0]   LOL_SAT     = '1;

  typedef enum logic [2:0] {
    ST_PWRDN     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_next;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_next;
  logic [RETRY_W-1:0] retry_inc;
  logic [LOL_W-1:0]   lol_next;
  logic               lock_meta;
  logic               lock_s;
  logic               pd_n_c;
  logic               sys_rst_c;
  logic               ready_c;
  logic               fail_c;

  assign state     = state_q;
  assign retry_inc = retry_q + RETRY_W'(1);

  // Two-flop synchronizer bringing the asynchronous LOCK into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PWRDN;
      cnt_q     <= '0;
      retry_q   <= '0;
      lol_cnt   <= '0;
      pll_pd_n  <= 1'b0;
      sys_rst   <= 1'b1;
      pll_ready <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_next;
      cnt_q     <= cnt_next;
      retry_q   <= retry_next;
      lol_cnt   <= lol_next;
      pll_pd_n  <= pd_n_c;
      sys_rst   <= sys_rst_c;
      pll_ready <= ready_c;
      fail      <= fail_c;
    end
  end

  // Next-state, timer, retry and loss-of-lock bookkeeping
  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q + CNT_W'(1);
    retry_next = retry_q;
    lol_next   = lol_cnt;
    case (state_q)
      ST_PWRDN: begin
        if (cnt_q == PD_LAST) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_next = retry_inc;
          cnt_next   = '0;
          state_next = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_PWRDN;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_next = ST_RUN;
          retry_next = '0;
          cnt_next   = '0;
        end
      end
      ST_RUN: begin
        cnt_next = '0;
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          if (lol_cnt != LOL_SAT) lol_next = lol_cnt + LOL_W'(1);
        end
      end
      ST_FAIL: begin
        cnt_next = '0;
      end
      default: begin
        // Illegal codes fall back to a clean power-down
        state_next = ST_PWRDN;
        cnt_next   = '0;
      end
    endcase
    // Restart overrides lock/timer events but keeps the loss-of-lock count
    if (restart) begin
      state_next = ST_PWRDN;
      cnt_next   = '0;
      retry_next = '0;
    end
  end

  // Output values for the state being entered, registered alongside it
  always_comb begin
    pd_n_c    = 1'b0;
    sys_rst_c = 1'b1;
    ready_c   = 1'b0;
    fail_c    = 1'b0;
    case (state_next)
      ST_WAIT_LOCK, ST_STABLE: begin
        pd_n_c = 1'b1;
      end
      ST_RUN: begin
        pd_n_c    = 1'b1;
        sys_rst_c = 1'b0;
        ready_c   = 1'b1;
      end
      ST_FAIL: begin
        fail_c = 1'b1;
      end
      default: begin
        pd_n_c = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq: directed scenarios plus a randomized phase,
// checked every cycle against a timestamp-based behavioural model.
`timescale 1ns/1ps
module tb_pll_reset_seq;

  localparam int PD = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int MR = 2;

  localparam int M_PWRDN  = 0;
  localparam int M_WAIT   = 1;
  localparam int M_STABLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAIL   = 4;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart  = 1'b0;
  logic       pll_pd_n;
  logic       sys_rst;
  logic       pll_ready;
  logic       fail;
  logic [2:0] state;
  logic [7:0] lol_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase plus the edge index at which it was entered
  int cyc     = 0;
  int m_state = M_PWRDN;
  int m_t0    = 0;
  int m_retry = 0;
  int m_lol   = 0;
  bit hist[$];

  pll_reset_seq #(
    .PD_CYCLES    (PD),
    .LOCK_TIMEOUT (TO),
    .STABLE_CYCLES(ST),
    .MAX_RETRY    (MR),
    .CNT_W        (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pll_lock (pll_lock),
    .restart  (restart),
    .pll_pd_n (pll_pd_n),
    .sys_rst  (sys_rst),
    .pll_ready(pll_ready),
    .fail     (fail),
    .state    (state),
    .lol_cnt  (lol_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    int nxt;
    bit ls;
    cyc++;
    if (rst) begin
      m_state = M_PWRDN;
      m_t0    = cyc;
      m_retry = 0;
      m_lol   = 0;
      hist.delete();
    end else begin
      // Lock as seen by the decision logic: the input two edges ago
      ls = (hist.size() == 2) ? hist[0] : 1'b0;
      hist.push_back(pll_lock);
      if (hist.size() > 2) void'(hist.pop_front());
      nxt = m_state;
      case (m_state)
        M_PWRDN:  if (cyc - m_t0 == PD) nxt = M_WAIT;
        M_WAIT: begin
          if (ls) nxt = M_STABLE;
          else if (cyc - m_t0 == TO) begin
            m_retry++;
            nxt = (m_retry == MR) ? M_FAIL : M_PWRDN;
          end
        end
        M_STABLE: begin
          if (!ls) nxt = M_WAIT;
          else if (cyc - m_t0 == ST) begin
            nxt = M_RUN;
            m_retry = 0;
          end
        end
        M_RUN: begin
          if (!ls) begin
            nxt = M_WAIT;
            if (m_lol < 255) m_lol++;
          end
        end
        default: nxt = m_state;
      endcase
      if (restart) begin
        nxt = M_PWRDN;
        m_retry = 0;
      end
      if (nxt != m_state || restart) m_t0 = cyc;
      m_state = nxt;
    end
  endtask

  // One clock: update model at the edge, compare all outputs 1ns later
  task automatic tick();
    bit e_pd;
    @(posedge clk);
    model_step();
    #1;
    e_pd = (m_state == M_WAIT) || (m_state == M_STABLE) || (m_state == M_RUN);
    chk("state",     8'(state),     8'(m_state));
    chk("pll_pd_n",  8'(pll_pd_n),  8'(e_pd));
    chk("sys_rst",   8'(sys_rst),   8'(m_state != M_RUN));
    chk("pll_ready", 8'(pll_ready), 8'(m_state == M_RUN));
    chk("fail",      8'(fail),      8'(m_state == M_FAIL));
    chk("lol_cnt",   lol_cnt,       8'(m_lol));
  endtask

  task automatic run_until_state(input int code, input int limit, output int n);
    n = 0;
    while (state !== 3'(code) && n < limit) begin
      tick();
      n++;
    end
    chk("reach_state", 8'(state), 8'(code));
  endtask

  task automatic run_until_rst(input logic val, input int limit, output int n);
    n = 0;
    while (sys_rst !== val && n < limit) begin
      tick();
      n++;
    end
    chk("reach_sys_rst", 8'(sys_rst), 8'(val));
  endtask

  initial begin
    int  n;
    int  d;
    int  hold;
    bit  saw_wait;
    bit  rst_low;

    // Reset values
    repeat (3) tick();
    chk("reset_state", 8'(state), 8'(0));
    chk("reset_pd_n", 8'(pll_pd_n), 8'(0));

    // 1. Nominal start
    rst = 1'b0;
    n = 0;
    while (pll_pd_n !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("pd_rise_cycle", 8'(n), 8'(PD));
    repeat (10) tick();
    pll_lock = 1'b1;
    run_until_state(M_STABLE, 20, n);
    chk("lock_to_stable", 8'(n), 8'(3));
    run_until_rst(1'b0, 50, n);
    chk("stable_to_release", 8'(n), 8'(ST));
    chk("nominal_ready", 8'(pll_ready), 8'(1));
    chk("nominal_state", 8'(state), 8'(M_RUN));

    // 2. Glitch during STABLE
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_state", 8'(state), 8'(M_PWRDN));
    chk("restart_pd_n", 8'(pll_pd_n), 8'(0));
    run_until_state(M_STABLE, 30, n);
    repeat (5) tick();
    pll_lock = 1'b0;
    saw_wait = 1'b0;
    rst_low  = 1'b0;
    repeat (3) begin
      tick();
      if (state === 3'(M_WAIT)) saw_wait = 1'b1;
      if (sys_rst !== 1'b1) rst_low = 1'b1;
    end
    pll_lock = 1'b1;
    run_until_state(M_STABLE, 20, n);
    chk("glitch_saw_wait", 8'(saw_wait), 8'(1));
    chk("glitch_no_release", 8'(rst_low), 8'(0));
    run_until_rst(1'b0, 50, n);
    chk("glitch_full_stable", 8'(n), 8'(ST));

    // 3. No lock: two timeouts then FAIL
    pll_lock = 1'b0;
    restart  = 1'b1;
    tick();
    restart = 1'b0;
    n = 0;
    while (fail !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("fail_latency", 8'(n), 8'(MR * (PD + TO)));
    repeat (60) tick();
    chk("fail_held", 8'(fail), 8'(1));
    chk("fail_pd_n", 8'(pll_pd_n), 8'(0));
    chk("fail_sys_rst", 8'(sys_rst), 8'(1));
    chk("fail_state", 8'(state), 8'(M_FAIL));

    // 4. Recovery from FAIL
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("recover_fail_clr", 8'(fail), 8'(0));
    pll_lock = 1'b1;
    run_until_rst(1'b0, 100, n);
    chk("recover_run", 8'(state), 8'(M_RUN));
    chk("recover_lol", lol_cnt, 8'(0));

    // 5. Loss of lock in RUN
    for (int i = 1; i <= 3; i++) begin
      pll_lock = 1'b0;
      run_until_rst(1'b1, 10, n);
      chk("lol_rst_latency", 8'(n), 8'(3));
      chk("lol_pd_n_kept", 8'(pll_pd_n), 8'(1));
      pll_lock = 1'b1;
      run_until_state(M_RUN, 40, n);
      chk("lol_count", lol_cnt, 8'(i));
    end
    for (int i = 0; i < 297; i++) begin
      d = int'($urandom_range(1, 4));
      pll_lock = 1'b0;
      repeat (d) tick();
      pll_lock = 1'b1;
      run_until_rst(1'b1, 10, n);
      run_until_state(M_RUN, 60, n);
    end
    chk("lol_saturate", lol_cnt, 8'(255));

    // 6a. rst in STABLE
    restart = 1'b1;
    tick();
    restart = 1'b0;
    run_until_state(M_STABLE, 30, n);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_stable_state", 8'(state), 8'(M_PWRDN));
    chk("rst_stable_pd_n", 8'(pll_pd_n), 8'(0));
    chk("rst_stable_lol", lol_cnt, 8'(0));

    // 6b. restart coinciding with lock loss in RUN
    run_until_state(M_RUN, 60, n);
    pll_lock = 1'b0;
    repeat (2) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_lol_state", 8'(state), 8'(M_PWRDN));
    chk("restart_lol_cnt", lol_cnt, 8'(1));

    // Randomized phase: random lock segments, occasional restart and rst
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pll_lock = ~pll_lock;
        hold = pll_lock ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 60));
      end
      hold--;
      d = int'($urandom_range(0, 199));
      restart = (d < 3);
      rst     = (d == 199);
      tick();
    end
    restart = 1'b0;
    rst     = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
